// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
// Optional feature macro used by muldiv_ctrl: MULDIV_DIV0_TRAP_EN.
package muldiv_pkg;
    localparam int ITER = 32;
    localparam int DW   = 2 * ITER;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIX   = 2'd2,
        WRITE = 2'd3
    } state_t;

    // v is {hi, lo}. Multiply negates the whole product; divide negates each half on its own.
    function automatic logic [DW-1:0] sign_fix(input logic [DW-1:0] v, input logic is_div,
                                               input logic neg_lo, input logic neg_hi);
        logic [ITER-1:0] hi, lo;
        if (!is_div) begin
            sign_fix = neg_lo ? -v : v;
        end else begin
            hi = neg_hi ? -v[DW-1:ITER] : v[DW-1:ITER];
            lo = neg_lo ? -v[ITER-1:0] : v[ITER-1:0];
            sign_fix = {hi, lo};
        end
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide over a {hi, lo} accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_sub;
    logic             borrow;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb & {WIDTH{acc[0]}}};
        // Partial remainder is WIDTH+1 bits; after a successful subtract it fits in WIDTH.
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        borrow   = shifted < {1'b0, opb};
        rem_sub  = shifted[WIDTH-1:0] - opb;
        if (!is_div)
            acc_next = {sum, acc[WIDTH-1:1]};
        else if (borrow)
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO write port.
// Define MULDIV_DIV0_TRAP_EN to trap divide-by-zero with a one-cycle div0 pulse.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
`ifdef MULDIV_DIV0_TRAP_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] wdilo,
    output logic [WIDTH-1:0] wdihi
);
    localparam int CW = $clog2(WIDTH);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_step, acc_fix;
    logic [WIDTH-1:0]   opb, a_mag, b_mag;
    logic               is_div, neg_lo, neg_hi;
    logic               is_mul_op, is_div_op, is_signed, trap, div0_q;

    assign is_mul_op = (op == MULT) || (op == MULTU);
    assign is_div_op = (op == DIV)  || (op == DIVU);
    assign is_signed = (op == MULT) || (op == DIV);
    assign a_mag     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    assign b_mag     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    assign acc_fix   = sign_fix(acc, is_div, neg_lo, neg_hi);

`ifdef MULDIV_DIV0_TRAP_EN
    assign trap = is_div_op && (srcb == '0);
    always_ff @(posedge clk) begin
        if (reset) div0_q <= 1'b0;
        else       div0_q <= (state == IDLE) && start && trap;
    end
    assign div0 = div0_q;
`else
    assign trap   = 1'b0;
    assign div0_q = 1'b0;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .opb      (opb),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == WRITE);
        hilo_we    = (state == WRITE) && !div0_q;
        case (state)
            IDLE: if (start) begin
                if (trap)                         state_next = WRITE;
                else if (is_mul_op || is_div_op)  state_next = RUN;
                else if (op == MTHI || op == MTLO) state_next = WRITE;
            end
            RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            wdilo  <= '0;
            wdihi  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt <= '0;
                    if ((is_mul_op || is_div_op) && !trap) begin
                        is_div <= is_div_op;
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        opb    <= b_mag;
                        // neg_lo: product or quotient sign; neg_hi: remainder follows dividend
                        neg_lo <= is_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_hi <= is_signed && srca[WIDTH-1];
                    end else if (op == MTHI) begin
                        wdihi <= srca;
                        wdilo <= lo_in;
                    end else if (op == MTLO) begin
                        wdihi <= hi_in;
                        wdilo <= srca;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX:     {wdihi, wdilo} <= acc_fix;
                default: ;
            endcase
        end
    end
endmodule
